// File: rtl/grant_bus_controller_pkg.sv
// Shared types and helpers for the grant bus controller: FSM encoding,
// requester index constants and grant-vector decode functions.
package grant_bus_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWN     = 2'b01,
    OVERRUN = 2'b10,
    ERROR   = 2'b11
  } state_t;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] REQ1 = 2'd1;
  localparam logic [1:0] REQ2 = 2'd2;
  localparam logic [1:0] REQ3 = 2'd3;

  function automatic logic is_onehot(input logic [2:0] gvec);
    return (gvec != 3'b000) && ((gvec & (gvec - 3'd1)) == 3'b000);
  endfunction

  // Index of a one-hot grant vector; NONE for anything else.
  function automatic logic [1:0] onehot_index(input logic [2:0] gvec);
    logic [1:0] idx;
    case (gvec)
      3'b001:  idx = REQ1;
      3'b010:  idx = REQ2;
      3'b100:  idx = REQ3;
      default: idx = NONE;
    endcase
    return idx;
  endfunction

  // One-hot mask selecting the owner's grant bit; zero when no owner.
  function automatic logic [2:0] owner_mask(input logic [1:0] owner);
    logic [2:0] mask;
    case (owner)
      REQ1:    mask = 3'b001;
      REQ2:    mask = 3'b010;
      REQ3:    mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/grant_bus_controller_bus_out_reg.sv
// Valid/ready output register carrying the shared-bus word and its owner tag.
// A load and a drain in the same cycle simply present the new word.
module bus_out_reg
  import grant_bus_controller_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [1:0]    load_owner,
  input  logic          bus_ready,
  output logic [DW-1:0] bus_data,
  output logic          bus_valid,
  output logic [1:0]    bus_owner
);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus_data  <= '0;
      bus_valid <= 1'b0;
      bus_owner <= NONE;
    end else if (load) begin
      bus_data  <= load_data;
      bus_valid <= 1'b1;
      bus_owner <= load_owner;
    end else if (bus_valid && bus_ready) begin
      bus_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/grant_bus_controller.sv
// Routes the granted requester onto a registered shared bus, limits grant
// tenure with release_req and latches illegal grant patterns as an error.
module grant_bus_controller
  import grant_bus_controller_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16,
  parameter int HW       = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          g1,
  input  logic          g2,
  input  logic          g3,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic          v1,
  input  logic          v2,
  input  logic          v3,
  output logic          rdy1,
  output logic          rdy2,
  output logic          rdy3,
  output logic [DW-1:0] bus_data,
  output logic          bus_valid,
  input  logic          bus_ready,
  output logic [1:0]    bus_owner,
  output logic          release_req,
  output logic          grant_error,
  output logic [HW-1:0] hold_count
);

  state_t        state, state_nxt;
  logic [1:0]    owner, owner_nxt;
  logic [HW-1:0] hold_nxt;

  logic [2:0]    gvec, vvec, mask, rdy_vec;
  logic          own_g, other_g, can_take, load;
  logic [DW-1:0] load_data;

  assign gvec     = {g3, g2, g1};
  assign vvec     = {v3, v2, v1};
  assign mask     = owner_mask(owner);
  assign own_g    = |(gvec & mask);
  assign other_g  = |(gvec & ~mask);
  assign can_take = ~bus_valid | bus_ready;

  // Only the tenure owner, still holding its grant, may be accepted.
  assign rdy_vec = (state == OWN) ? (gvec & mask & {3{can_take}}) : 3'b000;
  assign rdy1    = rdy_vec[0];
  assign rdy2    = rdy_vec[1];
  assign rdy3    = rdy_vec[2];
  assign load    = |(rdy_vec & vvec);

  always_comb begin
    case (owner)
      REQ2:    load_data = d2;
      REQ3:    load_data = d3;
      default: load_data = d1;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      owner      <= NONE;
      hold_count <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      hold_count <= hold_nxt;
    end
  end

  // NOTE: every signal written below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    hold_nxt  = hold_count;
    case (state)
      IDLE: begin
        hold_nxt = '0;
        if (is_onehot(gvec)) begin
          state_nxt = OWN;
          owner_nxt = onehot_index(gvec);
        end else if (gvec != 3'b000) begin
          state_nxt = ERROR;
        end
      end
      OWN: begin
        hold_nxt = hold_count + HW'(1);
        if (!own_g) begin
          // A hand-over always goes through IDLE, even if another grant rose.
          state_nxt = IDLE;
          owner_nxt = NONE;
          hold_nxt  = '0;
        end else if (other_g) begin
          state_nxt = ERROR;
        end else if (hold_count == HW'(MAX_HOLD - 1)) begin
          state_nxt = OVERRUN;
        end
      end
      OVERRUN: begin
        if (!own_g) begin
          state_nxt = IDLE;
          owner_nxt = NONE;
          hold_nxt  = '0;
        end else if (other_g) begin
          state_nxt = ERROR;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
    endcase
  end

  assign release_req = (state == OVERRUN);
  assign grant_error = (state == ERROR);

  bus_out_reg #(.DW(DW)) u_bus_out_reg (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (load),
    .load_data  (load_data),
    .load_owner (owner),
    .bus_ready  (bus_ready),
    .bus_data   (bus_data),
    .bus_valid  (bus_valid),
    .bus_owner  (bus_owner)
  );

endmodule

// File: tb/tb_grant_bus_controller.sv
// Directed bench for grant_bus_controller: a tenure/slot model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_grant_bus_controller;

  localparam int DW       = 8;
  localparam int MAX_HOLD = 16;
  localparam int HW       = 5;

  logic          Clock, Reset;
  logic          g1, g2, g3, v1, v2, v3;
  logic [DW-1:0] d1, d2, d3;
  logic          rdy1, rdy2, rdy3;
  logic [DW-1:0] bus_data;
  logic          bus_valid, bus_ready;
  logic [1:0]    bus_owner;
  logic          release_req, grant_error;
  logic [HW-1:0] hold_count;

  int checks = 0;
  int errors = 0;

  grant_bus_controller #(.DW(DW), .MAX_HOLD(MAX_HOLD), .HW(HW)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .g1          (g1),
    .g2          (g2),
    .g3          (g3),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .v1          (v1),
    .v2          (v2),
    .v3          (v3),
    .rdy1        (rdy1),
    .rdy2        (rdy2),
    .rdy3        (rdy3),
    .bus_data    (bus_data),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_owner   (bus_owner),
    .release_req (release_req),
    .grant_error (grant_error),
    .hold_count  (hold_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the tenure (0 = nobody), how long, whether it overran,
  // whether an illegal grant was ever seen, and the single bus slot.
  typedef struct {
    int          owner;
    int          tenure;
    bit          over;
    bit          err;
    bit          valid;
    logic [7:0]  data;
    int          tag;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.owner = 0; r.tenure = 0; r.over = 0; r.err = 0;
    r.valid = 0; r.data = '0; r.tag = 0;
    return r;
  endfunction

  function automatic bit exp_rdy(input model_t s, input int k, input logic [2:0] g, input logic rd);
    return (s.owner == k) && !s.over && !s.err && g[k-1] && (!s.valid || rd);
  endfunction

  function automatic model_t model_step(input model_t s, input logic [2:0] g, input logic [2:0] v,
                                        input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic rd);
    model_t n;
    int acc;
    int cnt;
    bit own, others;
    n = s;
    acc = 0;
    for (int k = 1; k <= 3; k++)
      if (exp_rdy(s, k, g, rd) && v[k-1]) acc = k;
    if (acc != 0) begin
      n.valid = 1;
      n.data  = (acc == 1) ? a : (acc == 2) ? b : c;
      n.tag   = acc;
    end else if (s.valid && rd) begin
      n.valid = 0;
    end
    if (s.err) begin
      n.err = 1;
    end else if (s.owner == 0) begin
      cnt = $countones(g);
      if (cnt == 1) begin
        n.owner  = g[0] ? 1 : (g[1] ? 2 : 3);
        n.tenure = 0;
      end else if (cnt > 1) begin
        n.err = 1;
      end
    end else begin
      own    = g[s.owner-1];
      others = (g & ~(3'b001 << (s.owner - 1))) != 3'b000;
      if (!own) begin
        n.owner = 0; n.over = 0; n.tenure = 0;
      end else if (others) begin
        n.err = 1; n.over = 0;
        if (!s.over) n.tenure = s.tenure + 1;
      end else if (!s.over) begin
        n.tenure = s.tenure + 1;
        if (s.tenure == MAX_HOLD - 1) n.over = 1;
      end
    end
    return n;
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) m <= model_reset();
    else m <= model_step(m, {g3, g2, g1}, {v3, v2, v1}, d1, d2, d3, bus_ready);
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge Clock) begin
    if (!Reset) begin
      check("rdy1", rdy1, exp_rdy(m, 1, {g3, g2, g1}, bus_ready));
      check("rdy2", rdy2, exp_rdy(m, 2, {g3, g2, g1}, bus_ready));
      check("rdy3", rdy3, exp_rdy(m, 3, {g3, g2, g1}, bus_ready));
      check("bus_valid", bus_valid, m.valid);
      check("bus_data", bus_data, m.data);
      check("bus_owner", bus_owner, m.tag);
      check("release_req", release_req, m.over && !m.err);
      check("grant_error", grant_error, m.err);
      check("hold_count", hold_count, m.tenure);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    {g1, g2, g3, v1, v2, v3} = '0;
    d1 = '0; d2 = '0; d3 = '0;
    bus_ready = 1'b1;
    tick();
    check("rst_bus_valid", bus_valid, 0);
    check("rst_bus_owner", bus_owner, 0);
    check("rst_hold", hold_count, 0);
    check("rst_err", grant_error, 0);
    tick();
    Reset = 1'b0;
    tick();

    // Single word from requester 2.
    g2 = 1; v2 = 1; d2 = 8'hA5;
    #1 check("t1_rdy2_idle", rdy2, 0);
    tick();
    check("t1_rdy2", rdy2, 1);
    check("t1_rdy1", rdy1, 0);
    check("t1_rdy3", rdy3, 0);
    tick();
    check("t1_data", bus_data, 8'hA5);
    check("t1_owner", bus_owner, 2);
    check("t1_valid", bus_valid, 1);
    g2 = 0; v2 = 0;
    tick();
    check("t1_drained", bus_valid, 0);
    tick();

    // Backpressured stream 01,02,03 from requester 1.
    g1 = 1; v1 = 1; d1 = 8'h01;
    tick();
    check("t2_rdy1", rdy1, 1);
    tick();
    check("t2_first", bus_data, 8'h01);
    bus_ready = 0; d1 = 8'h02;
    #1 check("t2_rdy1_stall", rdy1, 0);
    repeat (3) begin
      tick();
      check("t2_hold_data", bus_data, 8'h01);
      check("t2_hold_rdy", rdy1, 0);
    end
    bus_ready = 1;
    #1 check("t2_rdy1_resume", rdy1, 1);
    tick();
    check("t2_second", bus_data, 8'h02);
    d1 = 8'h03;
    tick();
    check("t2_third", bus_data, 8'h03);
    check("t2_third_valid", bus_valid, 1);
    v1 = 0;
    tick();
    check("t2_drained", bus_valid, 0);
    g1 = 0;
    tick();

    // Tenure overrun on requester 3.
    g3 = 1;
    tick();
    check("t3_hold0", hold_count, 0);
    repeat (15) tick();
    check("t3_hold15", hold_count, 15);
    check("t3_no_release", release_req, 0);
    v3 = 1;
    #1 check("t3_rdy3_last", rdy3, 1);
    tick();
    check("t3_release", release_req, 1);
    check("t3_hold16", hold_count, 16);
    check("t3_rdy3_off", rdy3, 0);
    tick();
    check("t3_hold_frozen", hold_count, 16);
    g3 = 0; v3 = 0;
    tick();
    check("t3_release_off", release_req, 0);
    check("t3_hold_idle", hold_count, 0);
    tick();

    // Hand-over 1 -> 2 in the same cycle passes through IDLE.
    g1 = 1;
    tick(); tick(); tick();
    check("t4_hold2", hold_count, 2);
    g1 = 0; g2 = 1;
    tick();
    check("t4_idle_rdy1", rdy1, 0);
    check("t4_idle_rdy2", rdy2, 0);
    check("t4_idle_rdy3", rdy3, 0);
    check("t4_idle_hold", hold_count, 0);
    tick();
    check("t4_own2_rdy2", rdy2, 1);
    check("t4_own2_hold", hold_count, 0);
    tick();
    check("t4_own2_hold1", hold_count, 1);
    g2 = 0;
    tick();

    // g2 rises during g1 tenure with a word pending: sticky error, drain.
    g1 = 1; v1 = 1; d1 = 8'h5A;
    tick(); tick();
    v1 = 0; bus_ready = 0; g2 = 1;
    tick();
    check("t5_err", grant_error, 1);
    check("t5_pending", bus_valid, 1);
    check("t5_pending_data", bus_data, 8'h5A);
    g1 = 0; g2 = 0;
    tick();
    g1 = 1;
    tick(); tick();
    check("t5_err_sticky", grant_error, 1);
    check("t5_no_rdy", rdy1, 0);
    bus_ready = 1;
    tick();
    check("t5_drained", bus_valid, 0);
    g1 = 0; Reset = 1;
    #1 check("t5_err_cleared", grant_error, 0);
    tick();
    Reset = 0;
    tick();

    // Two grants together from IDLE.
    g1 = 1; g2 = 1;
    tick();
    check("t6_err", grant_error, 1);
    g1 = 0; g2 = 0;
    tick();
    Reset = 1;
    #1 check("t6_err_cleared", grant_error, 0);
    Reset = 0;
    tick();

    // Asynchronous reset with a stalled word on the bus.
    g3 = 1; v3 = 1; d3 = 8'hC3;
    tick(); tick();
    bus_ready = 0; v3 = 0;
    tick();
    check("t7_valid", bus_valid, 1);
    check("t7_data", bus_data, 8'hC3);
    #2 Reset = 1;
    #1;
    check("t7_rst_valid", bus_valid, 0);
    check("t7_rst_data", bus_data, 0);
    check("t7_rst_owner", bus_owner, 0);
    check("t7_rst_hold", hold_count, 0);
    check("t7_rst_release", release_req, 0);
    check("t7_rst_err", grant_error, 0);
    check("t7_rst_rdy3", rdy3, 0);
    g3 = 0; bus_ready = 1;
    tick();
    Reset = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grant_bus_controller.md
Name: grant_bus_controller

Overview:
- Downstream consumer of the 3-requester arbiter's one-hot grants g1/g2/g3.
- Routes the granted requester's data words onto a single shared registered bus with valid/ready flow control.
- Enforces a maximum grant tenure: raises release_req when the owner holds the grant too long.
- Flags illegal grant patterns as a sticky error.

Parameters:
- DW, 8, data width of each requester and of the bus.
- MAX_HOLD, 16, maximum cycles of one grant tenure before release is requested (>=2).
- HW, 5, width of hold_count; must satisfy 2^HW > MAX_HOLD.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- g1, g2, g3  in  1 each  grants from the arbiter (expected one-hot or zero).
- d1, d2, d3  in  DW each  requester data.
- v1, v2, v3  in  1 each  requester data valid.
- rdy1, rdy2, rdy3  out  1 each  requester accept (combinational).
- bus_data  out  DW  registered shared-bus data.
- bus_valid  out  1  registered shared-bus valid.
- bus_ready  in  1  downstream accept.
- bus_owner  out  2  requester index (1..3) tagged to bus_data; 0 when never loaded.
- release_req  out  1  asks the current owner to drop its request.
- grant_error  out  1  sticky illegal-grant flag.
- hold_count  out  HW  cycles elapsed in the current tenure.

Behaviour:
- Clock and reset:
  - One clock domain; reset is asynchronous and active-high.
  - On Reset: state=IDLE, owner=0, bus_data=0, bus_valid=0, bus_owner=0, hold_count=0, release_req=0, grant_error=0.
- gvec={g3,g2,g1}; one-hot means exactly one bit set.
- rdyk = (state==OWN) & (owner==k) & gk & (~bus_valid | bus_ready). A requester is never accepted without its own grant high.
- Transfer: rdyk & vk at an edge loads bus_data<=dk, bus_owner<=k, bus_valid<=1. Latency is one cycle from accept to bus_valid.
- Output register:
  - With no load, bus_valid & bus_ready clears bus_valid.
  - With bus_valid & !bus_ready, bus_data and bus_owner hold stable.
  - Load and drain in the same cycle keeps bus_valid=1 and presents the new word (full throughput).
- IDLE:
  - rdy all 0, hold_count=0.
  - gvec one-hot: go to OWN with owner=index, hold_count=0.
  - gvec with >1 bit set: go to ERROR.
  - gvec zero: stay in IDLE.
- OWN:
  - hold_count increments each cycle.
  - Owner grant low: go to IDLE. This applies even if another grant rose the same cycle; a hand-over always passes through one IDLE cycle.
  - Owner grant high and any other grant high: go to ERROR.
  - Otherwise, hold_count==MAX_HOLD-1: go to OVERRUN.
- OVERRUN:
  - release_req=1, rdy all 0, hold_count holds.
  - Owner grant low: go to IDLE and release_req=0.
  - Any other grant high: go to ERROR.
- ERROR:
  - grant_error=1, rdy all 0, release_req=0.
  - Stays in ERROR until Reset. The output register still drains normally.
- Reset mid-transfer discards any pending bus word immediately: bus_valid=0.
- v without grant, or grant without v: no transfer and no error.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, OWN=2'b01, OVERRUN=2'b10, ERROR=2'b11;
  - owner index constants: NONE=0, REQ1=1, REQ2=2, REQ3=3.
- One sub-module is natural: bus_out_reg. It is the valid/ready output register holding data+owner tag, with load/drain logic.
- The FSM, the hold counter and the rdy decode stay in grant_bus_controller.

Test Plan:
- Reset, then g2=1 with v2=1, d2=8'hA5 and bus_ready=1. Required: rdy2=1 in the cycle after the grant is seen; next cycle bus_data=A5, bus_owner=2, bus_valid=1; rdy1=rdy3=0 throughout.
- g1=1 with v1 streaming 01,02,03 and bus_ready=0 after the first word. Required: bus_data stays 01; rdy1=0 until bus_ready=1; then 02 and 03 appear on consecutive cycles with no loss or duplication.
- g3 held with MAX_HOLD=16. Required: release_req=1 after 16 cycles in OWN and rdy3=0; drop g3, then release_req=0 and state IDLE the next cycle.
- g1 falls and g2 rises in the same cycle. Required: one IDLE cycle with all rdy=0, then OWN with owner 2 and hold_count restarting at 0.
- g1 and g2 both high (from IDLE, or g2 rising during g1 tenure). Required: grant_error=1 and sticky across later legal grants; a pending bus word still drains; Reset clears it.
- Assert Reset while bus_valid=1 and bus_ready=0. Required: all outputs go to their reset values asynchronously, before the next Clock edge.
